// File: rtl/read_blk_feeder.sv
// ---------------------------------------------------------------------------
// read_blk_feeder
//
// Sits directly upstream of read_sram on one output port. It takes one packet
// descriptor at a time. It walks the packet's block chain through the
// linked-list next-pointer RAM and hands each block base address to
// read_sram, paced by read_sram's almost-finish indication. Each block that
// read_sram has fully read goes back to the free-block manager.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_desc_vld/o_desc_rdy   descriptor handshake (head, blk_cnt, last_n)
//   o_ll_rd_en/addr         next-pointer RAM read; i_ll_rd_data 1 cycle later
//   o_blk_addr(_vld)        block base word address to read_sram (pulse)
//   o_last_blk_vld/_n       marks the final block and its word count
//   i_read_almost_finish    read_sram can take the next block address
//   i_read_finish           read_sram finished one block
//   o_free_vld/o_free_blk   released block index (same cycle as finish)
//   o_busy                  packet in progress
// ---------------------------------------------------------------------------
module read_blk_feeder #(
   parameter int AWIDTH     = 14,
   parameter int BLK_AWIDTH = 10,
   parameter int CWIDTH     = 10
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_desc_vld,
   output logic                         o_desc_rdy,
   input  logic [BLK_AWIDTH-1:0]        i_desc_head,
   input  logic [CWIDTH-1:0]            i_desc_blk_cnt,
   input  logic [AWIDTH-BLK_AWIDTH-1:0] i_desc_last_n,
   output logic                         o_ll_rd_en,
   output logic [BLK_AWIDTH-1:0]        o_ll_rd_addr,
   input  logic [BLK_AWIDTH-1:0]        i_ll_rd_data,
   output logic [AWIDTH-1:0]            o_blk_addr,
   output logic                         o_blk_addr_vld,
   output logic                         o_last_blk_vld,
   output logic [AWIDTH-BLK_AWIDTH-1:0] o_last_blk_n,
   input  logic                         i_read_almost_finish,
   input  logic                         i_read_finish,
   output logic                         o_free_vld,
   output logic [BLK_AWIDTH-1:0]        o_free_blk,
   output logic                         o_busy
);

   localparam int OFF_W = AWIDTH - BLK_AWIDTH;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_AF, WAIT_FIN} state_t;

   state_t                state_q, state_d;
   logic [BLK_AWIDTH-1:0] cur_idx_q, cur_idx_d;
   logic [BLK_AWIDTH-1:0] nxt_idx_q, nxt_idx_d;
   logic                  nxt_ok_q, nxt_ok_d;
   logic                  pending_q, pending_d;
   logic [CWIDTH-1:0]     rem_q, rem_d;
   logic [OFF_W-1:0]      last_n_q, last_n_d;
   logic                  rd_wait_q, rd_wait_d;
   logic [BLK_AWIDTH-1:0] fifo0_q, fifo0_d;
   logic [BLK_AWIDTH-1:0] fifo1_q, fifo1_d;
   logic [1:0]            fifo_cnt_q, fifo_cnt_d;
   logic                  desc_rdy_q, desc_rdy_d;
   logic                  busy_q, busy_d;
   logic                  ll_rd_en_q, ll_rd_en_d;
   logic [BLK_AWIDTH-1:0] ll_rd_addr_q, ll_rd_addr_d;
   logic [AWIDTH-1:0]     blk_addr_q, blk_addr_d;
   logic                  blk_addr_vld_q, blk_addr_vld_d;
   logic                  last_blk_vld_q, last_blk_vld_d;

   logic                  desc_xfer;
   logic                  issue;
   logic [BLK_AWIDTH-1:0] issue_idx;
   logic [CWIDTH-1:0]     issue_rem;
   logic                  push;
   logic                  pop;

   assign desc_xfer = i_desc_vld && desc_rdy_q;
   // The block presented in the ISSUE cycle enters the in-flight FIFO.
   assign push      = blk_addr_vld_q;
   // Finishes with nothing in flight, or during reset, release nothing.
   assign pop       = i_read_finish && (fifo_cnt_q != 2'd0) && !i_rst;

   always_comb begin
      // NOTE: every signal assigned here gets a default first so that no path
      // leaves it unassigned; a missing default infers a latch.
      state_d        = state_q;
      cur_idx_d      = cur_idx_q;
      nxt_idx_d      = nxt_idx_q;
      nxt_ok_d       = nxt_ok_q;
      pending_d      = pending_q;
      rem_d          = rem_q;
      last_n_d       = last_n_q;
      rd_wait_d      = ll_rd_en_q;
      fifo0_d        = fifo0_q;
      fifo1_d        = fifo1_q;
      fifo_cnt_d     = fifo_cnt_q;
      ll_rd_addr_d   = ll_rd_addr_q;
      blk_addr_d     = blk_addr_q;
      ll_rd_en_d     = 1'b0;
      blk_addr_vld_d = 1'b0;
      last_blk_vld_d = 1'b0;
      issue          = 1'b0;
      issue_idx      = cur_idx_q;
      issue_rem      = rem_q;

      // Successor index arrives the cycle after the LL read strobe.
      if (rd_wait_q) begin
         nxt_idx_d = i_ll_rd_data;
         nxt_ok_d  = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (desc_xfer) begin
               issue     = 1'b1;
               issue_idx = i_desc_head;
               issue_rem = (i_desc_blk_cnt == '0) ? CWIDTH'(1) : i_desc_blk_cnt;
               last_n_d  = i_desc_last_n;
            end
         end
         ISSUE: begin
            state_d = last_blk_vld_q ? WAIT_FIN : WAIT_AF;
         end
         WAIT_AF: begin
            // Same-cycle almost-finish counts as pending so the normal issue
            // latency is one cycle; otherwise remember it until the
            // successor index is known.
            if ((pending_q || i_read_almost_finish) && nxt_ok_q) begin
               issue     = 1'b1;
               issue_idx = nxt_idx_q;
               pending_d = 1'b0;
               nxt_ok_d  = 1'b0;
            end else if (i_read_almost_finish) begin
               pending_d = 1'b1;
            end
         end
         WAIT_FIN: begin
            if (pop && fifo_cnt_q == 2'd1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Registered outputs for the ISSUE cycle are prepared on entry.
      if (issue) begin
         state_d        = ISSUE;
         cur_idx_d      = issue_idx;
         rem_d          = issue_rem - CWIDTH'(1);
         blk_addr_vld_d = 1'b1;
         blk_addr_d     = {issue_idx, {OFF_W{1'b0}}};
         if (issue_rem == CWIDTH'(1)) begin
            last_blk_vld_d = 1'b1;
         end else begin
            ll_rd_en_d   = 1'b1;
            ll_rd_addr_d = issue_idx;
         end
      end

      desc_rdy_d = (state_d == IDLE);
      busy_d     = (state_d != IDLE);

      // Two-entry in-flight FIFO; fifo0 is always the oldest block.
      unique case ({push, pop})
         2'b10: begin
            if (fifo_cnt_q == 2'd0) begin
               fifo0_d    = cur_idx_q;
               fifo_cnt_d = 2'd1;
            end else if (fifo_cnt_q == 2'd1) begin
               fifo1_d    = cur_idx_q;
               fifo_cnt_d = 2'd2;
            end
         end
         2'b01: begin
            fifo0_d    = fifo1_q;
            fifo_cnt_d = fifo_cnt_q - 2'd1;
         end
         2'b11: begin
            if (fifo_cnt_q == 2'd1) begin
               fifo0_d = cur_idx_q;
            end else begin
               fifo0_d = fifo1_q;
               fifo1_d = cur_idx_q;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         // NOTE: the in-flight slots are reset together with their count;
         // they are only two flops and they drive o_free_blk directly.
         state_q        <= IDLE;
         cur_idx_q      <= '0;
         nxt_idx_q      <= '0;
         nxt_ok_q       <= 1'b0;
         pending_q      <= 1'b0;
         rem_q          <= '0;
         last_n_q       <= '0;
         rd_wait_q      <= 1'b0;
         fifo0_q        <= '0;
         fifo1_q        <= '0;
         fifo_cnt_q     <= 2'd0;
         desc_rdy_q     <= 1'b1;
         busy_q         <= 1'b0;
         ll_rd_en_q     <= 1'b0;
         ll_rd_addr_q   <= '0;
         blk_addr_q     <= '0;
         blk_addr_vld_q <= 1'b0;
         last_blk_vld_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cur_idx_q      <= cur_idx_d;
         nxt_idx_q      <= nxt_idx_d;
         nxt_ok_q       <= nxt_ok_d;
         pending_q      <= pending_d;
         rem_q          <= rem_d;
         last_n_q       <= last_n_d;
         rd_wait_q      <= rd_wait_d;
         fifo0_q        <= fifo0_d;
         fifo1_q        <= fifo1_d;
         fifo_cnt_q     <= fifo_cnt_d;
         desc_rdy_q     <= desc_rdy_d;
         busy_q         <= busy_d;
         ll_rd_en_q     <= ll_rd_en_d;
         ll_rd_addr_q   <= ll_rd_addr_d;
         blk_addr_q     <= blk_addr_d;
         blk_addr_vld_q <= blk_addr_vld_d;
         last_blk_vld_q <= last_blk_vld_d;
      end
   end

   assign o_desc_rdy     = desc_rdy_q;
   assign o_busy         = busy_q;
   assign o_ll_rd_en     = ll_rd_en_q;
   assign o_ll_rd_addr   = ll_rd_addr_q;
   assign o_blk_addr     = blk_addr_q;
   assign o_blk_addr_vld = blk_addr_vld_q;
   assign o_last_blk_vld = last_blk_vld_q;
   assign o_last_blk_n   = last_n_q;
   assign o_free_vld     = pop;
   assign o_free_blk     = fifo0_q;

endmodule

// File: tb/tb_read_blk_feeder.sv
// ---------------------------------------------------------------------------
// tb_read_blk_feeder
//
// Directed bench for read_blk_feeder. Descriptors push expected block
// addresses and expected free indices into queues; a negedge monitor pops
// and compares them whenever the DUT pulses o_blk_addr_vld or o_free_vld.
// The linked-list RAM is modelled here with one cycle of read latency.
// ---------------------------------------------------------------------------
module tb_read_blk_feeder;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_desc_vld;
   logic        o_desc_rdy;
   logic [9:0]  i_desc_head;
   logic [9:0]  i_desc_blk_cnt;
   logic [3:0]  i_desc_last_n;
   logic        o_ll_rd_en;
   logic [9:0]  o_ll_rd_addr;
   logic [9:0]  ll_data;
   logic [13:0] o_blk_addr;
   logic        o_blk_addr_vld;
   logic        o_last_blk_vld;
   logic [3:0]  o_last_blk_n;
   logic        i_read_almost_finish;
   logic        i_read_finish;
   logic        o_free_vld;
   logic [9:0]  o_free_blk;
   logic        o_busy;

   typedef struct {
      logic [13:0] addr;
      logic        last;
      logic [3:0]  last_n;
   } blk_exp_t;

   blk_exp_t   exp_blk[$];
   logic [9:0] exp_free[$];
   logic [9:0] ll_mem [0:1023];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   read_blk_feeder dut (
      .i_clk                (clk),
      .i_rst                (i_rst),
      .i_desc_vld           (i_desc_vld),
      .o_desc_rdy           (o_desc_rdy),
      .i_desc_head          (i_desc_head),
      .i_desc_blk_cnt       (i_desc_blk_cnt),
      .i_desc_last_n        (i_desc_last_n),
      .o_ll_rd_en           (o_ll_rd_en),
      .o_ll_rd_addr         (o_ll_rd_addr),
      .i_ll_rd_data         (ll_data),
      .o_blk_addr           (o_blk_addr),
      .o_blk_addr_vld       (o_blk_addr_vld),
      .o_last_blk_vld       (o_last_blk_vld),
      .o_last_blk_n         (o_last_blk_n),
      .i_read_almost_finish (i_read_almost_finish),
      .i_read_finish        (i_read_finish),
      .o_free_vld           (o_free_vld),
      .o_free_blk           (o_free_blk),
      .o_busy               (o_busy)
   );

   // Next-pointer RAM: registered read, data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (o_ll_rd_en) ll_data <= ll_mem[o_ll_rd_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one descriptor for a single cycle and records what it should yield.
   task automatic send_desc(input logic [9:0] head, input logic [9:0] cnt, input logic [3:0] lastn);
      int         n;
      logic [9:0] idx;
      blk_exp_t   e;
      n   = (cnt == 10'd0) ? 1 : int'(cnt);
      idx = head;
      for (int i = 0; i < n; i++) begin
         e.addr   = {idx, 4'b0000};
         e.last   = (i == n - 1);
         e.last_n = lastn;
         exp_blk.push_back(e);
         exp_free.push_back(idx);
         idx = ll_mem[idx];
      end
      i_desc_vld     = 1'b1;
      i_desc_head    = head;
      i_desc_blk_cnt = cnt;
      i_desc_last_n  = lastn;
      step();
      i_desc_vld     = 1'b0;
   endtask

   // Scoreboard side: compare every pulse the DUT produces against the queues.
   always @(negedge clk) begin
      blk_exp_t   e;
      logic [9:0] f;
      if (o_blk_addr_vld === 1'b1) begin
         check("blk_expected", 32'(exp_blk.size() > 0), 32'd1);
         if (exp_blk.size() > 0) begin
            e = exp_blk.pop_front();
            check("blk_addr", 32'(o_blk_addr), 32'(e.addr));
            check("blk_last", 32'(o_last_blk_vld), 32'(e.last));
            if (e.last) check("last_n", 32'(o_last_blk_n), 32'(e.last_n));
         end
      end
      if (o_free_vld === 1'b1) begin
         check("free_expected", 32'(exp_free.size() > 0), 32'd1);
         if (exp_free.size() > 0) begin
            f = exp_free.pop_front();
            check("free_blk", 32'(o_free_blk), 32'(f));
         end
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) ll_mem[i] = 10'd0;
      ll_mem[0]   = 10'd3;
      ll_mem[3]   = 10'd7;
      ll_mem[20]  = 10'd21;
      ll_mem[200] = 10'd201;
      ll_mem[201] = 10'd202;
      ll_mem[202] = 10'd203;
      ll_data     = 10'd0;

      // Reset held 3 cycles with a descriptor offered.
      i_rst = 1'b1;
      i_desc_vld = 1'b1;
      i_desc_head = 10'd9;
      i_desc_blk_cnt = 10'd2;
      i_desc_last_n = 4'd5;
      i_read_almost_finish = 1'b0;
      i_read_finish = 1'b0;
      repeat (3) step();
      check("rst_desc_rdy", 32'(o_desc_rdy), 32'd1);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_blk_vld", 32'(o_blk_addr_vld), 32'd0);
      check("rst_last_vld", 32'(o_last_blk_vld), 32'd0);
      check("rst_ll_rd_en", 32'(o_ll_rd_en), 32'd0);
      check("rst_ll_addr", 32'(o_ll_rd_addr), 32'd0);
      check("rst_blk_addr", 32'(o_blk_addr), 32'd0);
      check("rst_last_n", 32'(o_last_blk_n), 32'd0);
      check("rst_free_vld", 32'(o_free_vld), 32'd0);
      i_rst = 1'b0;
      i_desc_vld = 1'b0;
      step();
      check("post_rst_rdy", 32'(o_desc_rdy), 32'd1);
      check("post_rst_busy", 32'(o_busy), 32'd0);

      // Single-block packet.
      send_desc(10'd5, 10'd1, 4'd10);
      check("s1_blk_vld", 32'(o_blk_addr_vld), 32'd1);
      check("s1_addr", 32'(o_blk_addr), 32'd80);
      check("s1_last", 32'(o_last_blk_vld), 32'd1);
      check("s1_last_n", 32'(o_last_blk_n), 32'd10);
      check("s1_no_ll", 32'(o_ll_rd_en), 32'd0);
      check("s1_busy", 32'(o_busy), 32'd1);
      check("s1_rdy", 32'(o_desc_rdy), 32'd0);
      step();
      i_read_finish = 1'b1;
      #1;
      check("s1_free_vld", 32'(o_free_vld), 32'd1);
      check("s1_free_blk", 32'(o_free_blk), 32'd5);
      step();
      i_read_finish = 1'b0;
      check("s1_rdy_after", 32'(o_desc_rdy), 32'd1);
      check("s1_busy_after", 32'(o_busy), 32'd0);

      // Chain 0 -> 3 -> 7.
      send_desc(10'd0, 10'd3, 4'd10);
      check("c_b0_addr", 32'(o_blk_addr), 32'd0);
      check("c_b0_ll_en", 32'(o_ll_rd_en), 32'd1);
      check("c_b0_ll_addr", 32'(o_ll_rd_addr), 32'd0);
      step();
      step();
      check("c_wait_no_vld", 32'(o_blk_addr_vld), 32'd0);
      i_read_almost_finish = 1'b1;
      step();
      i_read_almost_finish = 1'b0;
      check("c_b1_vld", 32'(o_blk_addr_vld), 32'd1);
      check("c_b1_addr", 32'(o_blk_addr), 32'd48);
      check("c_b1_ll_addr", 32'(o_ll_rd_addr), 32'd3);
      i_read_finish = 1'b1;
      #1;
      check("c_free0_vld", 32'(o_free_vld), 32'd1);
      check("c_free0_blk", 32'(o_free_blk), 32'd0);
      step();
      i_read_finish = 1'b0;
      step();
      i_read_almost_finish = 1'b1;
      step();
      i_read_almost_finish = 1'b0;
      check("c_b2_vld", 32'(o_blk_addr_vld), 32'd1);
      check("c_b2_addr", 32'(o_blk_addr), 32'd112);
      check("c_b2_last", 32'(o_last_blk_vld), 32'd1);
      check("c_b2_no_ll", 32'(o_ll_rd_en), 32'd0);
      i_read_finish = 1'b1;
      #1;
      check("c_free3_blk", 32'(o_free_blk), 32'd3);
      step();
      i_read_finish = 1'b0;
      check("c_not_idle", 32'(o_busy), 32'd1);
      step();
      i_read_finish = 1'b1;
      #1;
      check("c_free7_blk", 32'(o_free_blk), 32'd7);
      step();
      i_read_finish = 1'b0;
      check("c_rdy_after", 32'(o_desc_rdy), 32'd1);

      // Almost-finish while the successor is still being fetched.
      send_desc(10'd20, 10'd2, 4'd1);
      step();
      i_read_almost_finish = 1'b1;
      step();
      i_read_almost_finish = 1'b0;
      check("af_early_no_vld", 32'(o_blk_addr_vld), 32'd0);
      step();
      check("af_early_vld", 32'(o_blk_addr_vld), 32'd1);
      check("af_early_addr", 32'(o_blk_addr), 32'd336);
      step();
      check("af_no_dup", 32'(o_blk_addr_vld), 32'd0);
      i_read_finish = 1'b1;
      step();
      step();
      i_read_finish = 1'b0;
      check("af_idle", 32'(o_busy), 32'd0);

      // Zero block count behaves as one.
      send_desc(10'd100, 10'd0, 4'd3);
      check("z_addr", 32'(o_blk_addr), 32'd1600);
      check("z_last", 32'(o_last_blk_vld), 32'd1);
      check("z_no_ll", 32'(o_ll_rd_en), 32'd0);
      step();
      i_read_finish = 1'b1;
      step();
      i_read_finish = 1'b0;
      check("z_idle", 32'(o_desc_rdy), 32'd1);

      // Reset while waiting for almost-finish in a 4-block packet.
      send_desc(10'd200, 10'd4, 4'd9);
      step();
      i_rst = 1'b1;
      i_read_almost_finish = 1'b1;
      i_read_finish = 1'b1;
      #1;
      check("r_no_free_in_rst", 32'(o_free_vld), 32'd0);
      step();
      exp_blk.delete();
      exp_free.delete();
      check("r_busy", 32'(o_busy), 32'd0);
      check("r_rdy", 32'(o_desc_rdy), 32'd1);
      check("r_blk_vld", 32'(o_blk_addr_vld), 32'd0);
      i_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("r_quiet_free", 32'(o_free_vld), 32'd0);
         check("r_quiet_blk", 32'(o_blk_addr_vld), 32'd0);
      end
      i_read_almost_finish = 1'b0;
      i_read_finish = 1'b0;
      step();
      send_desc(10'd50, 10'd1, 4'd7);
      check("r_new_addr", 32'(o_blk_addr), 32'd800);
      check("r_new_last", 32'(o_last_blk_vld), 32'd1);
      step();
      i_read_finish = 1'b1;
      #1;
      check("r_new_free", 32'(o_free_blk), 32'd50);
      step();
      i_read_finish = 1'b0;
      step();
      check("r_new_idle", 32'(o_desc_rdy), 32'd1);

      check("exp_blk_drained", 32'(exp_blk.size()), 32'd0);
      check("exp_free_drained", 32'(exp_free.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
